// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 8-digit hex driver for a common-anode
// seven-segment display. A prescaler holds each digit for SCAN_DIV clocks.
// A newly loaded value is only adopted at a frame boundary. This means one
// scan frame never shows digits from two different values.
//
// Load interface: display_we is a single-cycle write strobe with no
// back-pressure. Every cycle with display_we=1 (and rst_n=1) captures
// display. The last capture before a frame boundary is the one shown. A
// capture on the boundary cycle itself goes straight to the shown register.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display,
  input  logic        display_we,
  input  logic        lz_blank,
  output logic [7:0]  digitalLocation,
  output logic [7:0]  digitalStates,
  output logic        frame_tick,
  output logic        pending
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [31:0]   shown_reg;
  logic [31:0]   pend_reg;
  logic          terminal;
  logic          boundary;
  logic [3:0]    cur_nib;
  logic          cur_blank;
  logic [7:0]    cur_seg;

  // Hex digit to active-low segments (bit0=a .. bit6=g, bit7=dp kept off).
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Scan timing: last prescaler count, and last count of the last digit.
  always_comb begin
    terminal = (pcnt == PLAST);
    boundary = terminal && (idx == 3'd7);
  end

  // Current digit decode. A digit above 0 is blanked when it and all higher
  // nibbles are zero.
  always_comb begin
    cur_nib   = shown_reg[{idx, 2'b00} +: 4];
    cur_blank = lz_blank && (idx != 3'd0) && ((shown_reg >> {idx, 2'b00}) == 32'd0);
    cur_seg   = cur_blank ? 8'hFF : seg7(cur_nib);
  end

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= 3'd0;
    end else begin
      pcnt <= terminal ? '0 : pcnt + 1'b1;
      if (terminal) idx <= idx + 3'd1;
    end
  end

  // Double buffer. A load goes to pend_reg. At a boundary shown_reg takes
  // the freshest value: a same-cycle load wins over an older pending one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg  <= 32'd0;
      shown_reg <= 32'd0;
      pending   <= 1'b0;
    end else begin
      if (display_we) pend_reg <= display;
      if (boundary) begin
        if (display_we)   shown_reg <= display;
        else if (pending) shown_reg <= pend_reg;
        pending <= 1'b0;
      end else if (display_we) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind idx/shown_reg.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digitalLocation <= 8'hFF;
      digitalStates   <= 8'hFF;
      frame_tick      <= 1'b0;
    end else begin
      digitalLocation <= ~(8'b1 << idx);
      digitalStates   <= cur_seg;
      frame_tick      <= boundary;
    end
  end

endmodule
